// File: rtl/stereo_write_buffer_if.sv
// Sample/CODEC-side signal bundle for stereo_write_buffer.
// The slave modport is the buffer itself; the master modport is the filter/CODEC environment.
interface stereo_write_buffer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int OUT_W  = 24
);
  logic [DATA_W-1:0]      in_left;
  logic                   left_valid;
  logic [DATA_W-1:0]      in_right;
  logic                   right_valid;
  logic                   codec_write_ready;
  logic                   write;
  logic [OUT_W-1:0]       writedata_left;
  logic [OUT_W-1:0]       writedata_right;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   pair_error;

  modport slave (
    input  in_left, left_valid, in_right, right_valid, codec_write_ready,
    output write, writedata_left, writedata_right, fifo_count, overflow, pair_error
  );

  modport master (
    output in_left, left_valid, in_right, right_valid, codec_write_ready,
    input  write, writedata_left, writedata_right, fifo_count, overflow, pair_error
  );
endinterface

// File: rtl/stereo_write_buffer.sv
// Pairs independently-timed left/right FIR samples, queues them, and issues one CODEC write per pair.
// Optional MONO_MIX_EN: both lanes carry (left + right) >>> 1 instead of their own channel.
//   state | meaning
//   IDLE  | waiting for a queued pair and codec_write_ready
//   ISSUE | write pulse high for this single cycle
//   WAIT  | one dead cycle so the CODEC can drop write_ready
module stereo_write_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int OUT_W  = 24
) (
  input logic                  ck,
  input logic                  rst_n,
  stereo_write_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              f_l, f_r;
  logic [DATA_W-1:0] mem_l [DEPTH];
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              write_q, overflow_q, pair_error_q;
  logic [OUT_W-1:0]  wd_l, wd_r;

  logic              push, pop, full, accept;
  logic [DATA_W-1:0] lane_l, lane_r;
  logic [OUT_W-1:0]  head_l, head_r;

`ifdef MONO_MIX_EN
  // One extra bit of headroom makes the sum exact; the shift brings it back to DATA_W.
  logic signed [DATA_W:0] mix_sum;
  logic signed [DATA_W:0] mix_half;
  assign mix_sum  = $signed({hold_l[DATA_W-1], hold_l}) + $signed({hold_r[DATA_W-1], hold_r});
  assign mix_half = mix_sum >>> 1;
  assign lane_l   = mix_half[DATA_W-1:0];
  assign lane_r   = mix_half[DATA_W-1:0];
`else
  assign lane_l = hold_l;
  assign lane_r = hold_r;
`endif

  assign push   = f_l & f_r;
  assign pop    = (state == IDLE) && (count != '0) && bus.codec_write_ready;
  assign full   = (count == CW'(DEPTH));
  assign accept = push && (!full || pop);
  assign head_l = OUT_W'(mem_l[rd_ptr]) << (OUT_W - DATA_W);
  assign head_r = OUT_W'(mem_r[rd_ptr]) << (OUT_W - DATA_W);

  always_ff @(posedge ck) begin
    if (accept) begin
      mem_l[wr_ptr] <= lane_l;
      mem_r[wr_ptr] <= lane_r;
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_l       <= '0;
      hold_r       <= '0;
      f_l          <= 1'b0;
      f_r          <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      write_q      <= 1'b0;
      wd_l         <= '0;
      wd_r         <= '0;
      overflow_q   <= 1'b0;
      pair_error_q <= 1'b0;
    end else begin
      // A new sample re-arms its flag even on the edge the held pair is pushed.
      if (bus.left_valid) begin
        hold_l <= bus.in_left;
        f_l    <= 1'b1;
      end else if (push) begin
        f_l <= 1'b0;
      end
      if (bus.right_valid) begin
        hold_r <= bus.in_right;
        f_r    <= 1'b1;
      end else if (push) begin
        f_r <= 1'b0;
      end
      if ((bus.left_valid && f_l && !f_r) || (bus.right_valid && f_r && !f_l))
        pair_error_q <= 1'b1;
      if (push && !accept)
        overflow_q <= 1'b1;
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};

      case (state)
        IDLE: begin
          if (pop) begin
            write_q <= 1'b1;
            wd_l    <= head_l;
            wd_r    <= head_r;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          write_q <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          state <= IDLE;
        end
        default: begin
          write_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.write           = write_q;
  assign bus.writedata_left  = wd_l;
  assign bus.writedata_right = wd_r;
  assign bus.fifo_count      = count;
  assign bus.overflow        = overflow_q;
  assign bus.pair_error      = pair_error_q;
endmodule

// File: tb/tb_stereo_write_buffer.sv
// Directed bench for stereo_write_buffer: per-cycle vector table plus overflow, reset and mono-mix sequences.
module tb_stereo_write_buffer;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  always #5 ck = ~ck;

  stereo_write_buffer_if #(.DATA_W(16), .DEPTH(4), .OUT_W(24)) bus ();

  stereo_write_buffer #(.DATA_W(16), .DEPTH(4), .OUT_W(24)) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        lv;
    logic [15:0] l;
    logic        rv;
    logic [15:0] r;
    logic        rdy;
    logic        w;
    logic [15:0] el;
    logic [15:0] er;
    logic [2:0]  cnt;
    logic        ovf;
    logic        perr;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs [NV];

  function automatic vec_t mk(input int r, input int lv, input int l, input int rv, input int rr,
                              input int rdy, input int w, input int el, input int er,
                              input int cnt, input int ovf, input int perr);
    vec_t v;
    v.rst = r[0];  v.lv = lv[0]; v.l = l[15:0]; v.rv = rv[0]; v.r = rr[15:0];
    v.rdy = rdy[0]; v.w = w[0]; v.el = el[15:0]; v.er = er[15:0];
    v.cnt = cnt[2:0]; v.ovf = ovf[0]; v.perr = perr[0];
    return v;
  endfunction

  // Expected CODEC word for a pair: own channel, or the arithmetic mean when mono mix is built in.
  function automatic logic [23:0] expw(input logic [15:0] l, input logic [15:0] r, input bit sel_r);
`ifdef MONO_MIX_EN
    logic signed [16:0] s;
    s = $signed({l[15], l}) + $signed({r[15], r});
    return {s[16:1], 8'h00};
`else
    return sel_r ? {r, 8'h00} : {l, 8'h00};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic lv, input logic [15:0] l,
                      input logic rv, input logic [15:0] rr, input logic rdy);
    rst_n = r;
    bus.left_valid = lv;
    bus.in_left = l;
    bus.right_valid = rv;
    bus.in_right = rr;
    bus.codec_write_ready = rdy;
    @(posedge ck);
    #1;
  endtask

  logic [15:0] pl [5];
  logic [15:0] pr [5];

  initial begin
    // reset with strobes active, basic pair, pair error, simultaneous push/pop/valids
    vecs[0]  = mk(0,1,'hAAAA,1,'h5555,1, 0,0,0,0,0,0);
    vecs[1]  = mk(0,1,'hAAAA,1,'h5555,1, 0,0,0,0,0,0);
    vecs[2]  = mk(1,1,'h1234,0,0,1,      0,0,0,0,0,0);
    vecs[3]  = mk(1,0,0,0,0,1,           0,0,0,0,0,0);
    vecs[4]  = mk(1,0,0,0,0,1,           0,0,0,0,0,0);
    vecs[5]  = mk(1,0,0,0,0,1,           0,0,0,0,0,0);
    vecs[6]  = mk(1,0,0,0,0,1,           0,0,0,0,0,0);
    vecs[7]  = mk(1,0,0,1,'hFEDC,1,      0,0,0,0,0,0);
    vecs[8]  = mk(1,0,0,0,0,1,           0,0,0,1,0,0);
    vecs[9]  = mk(1,0,0,0,0,1,           1,'h1234,'hFEDC,0,0,0);
    vecs[10] = mk(1,0,0,0,0,1,           0,'h1234,'hFEDC,0,0,0);
    vecs[11] = mk(1,0,0,0,0,1,           0,'h1234,'hFEDC,0,0,0);
    vecs[12] = mk(1,1,'h1111,0,0,1,      0,'h1234,'hFEDC,0,0,0);
    vecs[13] = mk(1,1,'h2222,0,0,1,      0,'h1234,'hFEDC,0,0,1);
    vecs[14] = mk(1,0,0,1,'h3333,1,      0,'h1234,'hFEDC,0,0,1);
    vecs[15] = mk(1,0,0,0,0,1,           0,'h1234,'hFEDC,1,0,1);
    vecs[16] = mk(1,0,0,0,0,1,           1,'h2222,'h3333,0,0,1);
    vecs[17] = mk(1,0,0,0,0,1,           0,'h2222,'h3333,0,0,1);
    vecs[18] = mk(1,0,0,0,0,1,           0,'h2222,'h3333,0,0,1);
    vecs[19] = mk(1,1,'h0A0A,1,'h0B0B,0, 0,'h2222,'h3333,0,0,1);
    vecs[20] = mk(1,0,0,0,0,0,           0,'h2222,'h3333,1,0,1);
    vecs[21] = mk(1,1,'h0C0C,1,'h0D0D,0, 0,'h2222,'h3333,1,0,1);
    vecs[22] = mk(1,1,'h0100,1,'h0200,1, 1,'h0A0A,'h0B0B,1,0,1);
    vecs[23] = mk(1,0,0,0,0,1,           0,'h0A0A,'h0B0B,2,0,1);
    vecs[24] = mk(1,0,0,0,0,1,           0,'h0A0A,'h0B0B,2,0,1);
    vecs[25] = mk(1,0,0,0,0,1,           1,'h0C0C,'h0D0D,1,0,1);
    vecs[26] = mk(1,0,0,0,0,1,           0,'h0C0C,'h0D0D,1,0,1);
    vecs[27] = mk(1,0,0,0,0,1,           0,'h0C0C,'h0D0D,1,0,1);
    vecs[28] = mk(1,0,0,0,0,1,           1,'h0100,'h0200,0,0,1);
    vecs[29] = mk(1,0,0,0,0,1,           0,'h0100,'h0200,0,0,1);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].lv, vecs[i].l, vecs[i].rv, vecs[i].r, vecs[i].rdy);
      chk($sformatf("vec%0d{write,wl,wr,count,ovf,perr}", i),
          64'({bus.write, bus.writedata_left, bus.writedata_right, bus.fifo_count,
               bus.overflow, bus.pair_error}),
          64'({vecs[i].w, expw(vecs[i].el, vecs[i].er, 1'b0), expw(vecs[i].el, vecs[i].er, 1'b1),
               vecs[i].cnt, vecs[i].ovf, vecs[i].perr}));
    end

    // backpressure: five pairs into a four-deep FIFO, then drain
    step(0,0,0,0,0,0);
    step(0,0,0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      pl[k] = 16'(16'h1111 * (k + 1));
      pr[k] = ~pl[k];
      step(1,1,pl[k],1,pr[k],0);
      step(1,0,0,0,0,0);
      chk($sformatf("ovf_fill%0d{count,ovf}", k),
          64'({bus.fifo_count, bus.overflow}),
          64'({3'((k < 4) ? k + 1 : 4), (k == 4) ? 1'b1 : 1'b0}));
    end
    begin
      int pulses = 0;
      int last = -10;
      for (int c = 0; c < 30; c++) begin
        step(1,0,0,0,0,1);
        if (bus.write) begin
          if (pulses < 4)
            chk($sformatf("drain%0d{wl,wr}", pulses),
                64'({bus.writedata_left, bus.writedata_right}),
                64'({expw(pl[pulses], pr[pulses], 1'b0), expw(pl[pulses], pr[pulses], 1'b1)}));
          if (pulses > 0)
            chk($sformatf("drain%0d_spacing_ge3", pulses), 64'(c - last >= 3), 64'(1));
          pulses++;
          last = c;
        end
      end
      chk("drain_pulse_count", 64'(pulses), 64'(4));
      chk("drain_end{count,ovf}", 64'({bus.fifo_count, bus.overflow}), 64'({3'd0, 1'b1}));
    end

    // reset while a write pulse is high discards the queue
    begin
      int seen = 0;
      step(0,0,0,0,0,0);
      step(1,1,16'h4444,1,16'h5555,0);
      step(1,0,0,0,0,0);
      step(1,1,16'h6666,1,16'h7777,0);
      step(1,0,0,0,0,0);
      chk("midrst_queued", 64'(bus.fifo_count), 64'(2));
      for (int c = 0; c < 5 && seen == 0; c++) begin
        step(1,0,0,0,0,1);
        if (bus.write) seen = 1;
      end
      chk("midrst_pulse_seen", 64'(seen), 64'(1));
      step(0,0,0,0,0,1);
      chk("midrst_cut{write,count,wl,ovf}",
          64'({bus.write, bus.fifo_count, bus.writedata_left, bus.overflow}),
          64'({1'b0, 3'd0, 24'h0, 1'b0}));
      seen = 0;
      for (int c = 0; c < 5; c++) begin
        step(1,0,0,0,0,1);
        if (bus.write || bus.fifo_count != 3'd0) seen = 1;
      end
      chk("midrst_no_replay", 64'(seen), 64'(0));
    end

`ifdef MONO_MIX_EN
    begin
      logic [23:0] got_l [2];
      logic [23:0] got_r [2];
      int n = 0;
      step(0,0,0,0,0,0);
      step(1,1,16'h7FFF,1,16'h7FFF,0);
      step(1,0,0,0,0,0);
      step(1,1,16'h8000,1,16'h0001,0);
      step(1,0,0,0,0,0);
      for (int c = 0; c < 12 && n < 2; c++) begin
        step(1,0,0,0,0,1);
        if (bus.write) begin
          got_l[n] = bus.writedata_left;
          got_r[n] = bus.writedata_right;
          n++;
        end
      end
      chk("mono_pulses", 64'(n), 64'(2));
      if (n == 2) begin
        chk("mono_max{wl,wr}", 64'({got_l[0], got_r[0]}), 64'({24'h7FFF00, 24'h7FFF00}));
        chk("mono_neg{wl,wr}", 64'({got_l[1], got_r[1]}), 64'({24'hC00000, 24'hC00000}));
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
